fft_reorder_ctrl: RTL and testbench
===================================

# fft_reorder_ctrl

Sequencing controller for one `RAM64` single-port frame buffer (64 words, 2-cycle read latency, `ED`-gated). It accepts one 64-sample frame in natural order, writing it to RAM addresses 0..63. It then reads the frame back in 6-bit bit-reversed order, or natural order, and flags each valid `DO` word with `RDY`. It sits at the FFT output, between the last butterfly stage and the output interface.

## Interface
- `AW`, default 6: address width; frame length N = 2^AW; must match the RAM depth.
- `LAT`, default 2: RAM read latency in `ED`-enabled cycles.

- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ED`  in  1  global enable; when low, all state, counters and the `RDY` pipeline hold.
- `START`  in  1  frame start; coincides with sample 0 on the RAM `DI` bus.
- `BITREV`  in  1  read-order select, sampled on the accepted `START`: 1 = bit-reversed, 0 = natural.
- `RAM_ED`  out  1  equals `ED`; drives the RAM enable.
- `RAM_WE`  out  1  RAM write enable; combinational.
- `RAM_ADDR`  out  AW  RAM address; combinational.
- `RDY`  out  1  RAM `DO` holds a valid output sample this cycle.
- `BUSY`  out  1  a frame is loading or draining; high when state is not IDLE.
- `START_ERR`  out  1  one-cycle pulse when `START` is ignored while `BUSY`.

## Operation
- States: IDLE, LOAD, DRAIN. Counter `cnt[AW-1:0]`. Latched read-order flag `brv`.
- All transitions, counter updates and pipeline shifts occur only when `ED`=1.
- IDLE:
  - `RAM_WE` = `START`, `RAM_ADDR` = 0.
  - On `START`: write sample 0, set `cnt`=1, latch `brv`=`BITREV`, go to LOAD.
- LOAD:
  - `RAM_WE`=1, `RAM_ADDR`=`cnt`, `cnt`++.
  - At `cnt`=N-1: write the last sample, set `cnt`=0, go to DRAIN.
- DRAIN:
  - `RAM_WE`=0.
  - `RAM_ADDR` = bit-reverse(`cnt`) if `brv`, else `cnt`.
  - `cnt`++; at `cnt`=N-1, go to IDLE with `cnt`=0.
- Read-valid pipeline: LAT-stage shift register. Input is 1 in DRAIN cycles, 0 otherwise. `RDY` is the last stage.
- `START` in LOAD or DRAIN: ignored, with no effect on state or `brv`, and `START_ERR` pulses. `START` with `ED`=0 is ignored without error.
- Back-to-back frames are allowed: `START` in the first IDLE cycle after DRAIN is accepted. The `RDY` tail of the previous frame keeps flushing. No address conflict arises: the new writes go to 0, 1, while the in-flight reads are 31 and 63 (bit-reversed) or 62 and 63 (natural).
- Bit reverse, AW=6: `a[5:0]` maps to `{a0,a1,a2,a3,a4,a5}`.

## Timing
- Reset values: state IDLE, `cnt`=0, `brv`=0, `RDY` pipeline all 0.
  - Outputs after reset: `RDY`=0, `BUSY`=0, `START_ERR`=0, `RAM_WE`=0 (while `START`=0), `RAM_ADDR`=0.
- Reset takes priority over `ED`. Reset mid-frame aborts immediately: the `RDY` pipeline is cleared and RAM contents are not cleared.
- Load: N `ED` cycles, counting the `START` cycle. Drain: N `ED` cycles.
- `RDY` first goes high LAT `ED`-cycles after the first DRAIN cycle. It stays high for N `ED`-cycles, with the k-th `RDY` word being RAM[bitrev(k)] (or RAM[k] when `brv`=0).
- Frame latency with `ED` held high: `START` at cycle 0 gives the first `RDY` at cycle N+LAT = 66 and the last at cycle 2N+LAT-1 = 129.
- `BUSY` rises the cycle after the accepted `START` and falls after the last DRAIN cycle.
- `START_ERR` is registered; it is high in the cycle after the offending `START`.
- When `ED`=0, `RAM_WE` may assert combinationally, but the RAM ignores it because `RAM_ED`=0.

## Test plan
- Natural load with bit-reverse read: `BITREV`=1, `ED`=1, `DI`=0..63 from `START` at cycle 0. Required: `RDY` high for cycles 66..129; `DO` sequence 0, 32, 16, 48, 8, …, 31, 63.
- Natural read: `BITREV`=0, same stimulus. Required: `DO` = 0..63 in order on `RDY` cycles 66..129.
- `ED` gaps: drop `ED` low for 3 cycles every 5th cycle during load and drain. Required: the same 64-word sequence as the first scenario, `RDY` never high while `ED`=0, and no word lost or duplicated.
- Back-to-back frames: second `START` (`DI`=100..163) exactly at cycle 128. Required: first-frame output is intact through cycle 129; second-frame `RDY` runs from cycle 194 with `DO` 100, 132, 116, ….
- Illegal `START`: pulse `START` at cycles 10 (LOAD) and 80 (DRAIN). Required: `START_ERR` high at cycles 11 and 81, and the frame output is unchanged.
- Reset mid-frame: assert `RST` at cycle 70 for 1 cycle. Required: `RDY`=0 and `BUSY`=0 from cycle 71; a new `START` at cycle 75 produces a correct full frame with first `RDY` at cycle 141.

Source files
------------

// File: rtl/fft_reorder_ctrl_if.sv
// Control/status bundle between the FFT reorder controller and its
// environment: enable, frame start, read-order select, RAM control and
// output flags.
interface fft_reorder_ctrl_if #(
    parameter int AW = 6
);
    logic          ED;
    logic          START;
    logic          BITREV;
    logic          RAM_ED;
    logic          RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic          RDY;
    logic          BUSY;
    logic          START_ERR;

    // Controller side
    modport slave (
        input  ED, START, BITREV,
        output RAM_ED, RAM_WE, RAM_ADDR, RDY, BUSY, START_ERR
    );

    // Environment side
    modport master (
        output ED, START, BITREV,
        input  RAM_ED, RAM_WE, RAM_ADDR, RDY, BUSY, START_ERR
    );
endinterface

// File: rtl/fft_reorder_ctrl.sv
// FFT output reorder controller. Loads one N-sample frame into a single-port
// RAM in natural order, then drains it in bit-reversed or natural order and
// flags each valid RAM output word with RDY.
module fft_reorder_ctrl #(
    parameter int AW  = 6,
    parameter int LAT = 2
) (
    input  logic               CLK,
    input  logic               RST,
    fft_reorder_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t         state_reg;
    logic [AW-1:0]  cnt_reg;
    logic [AW-1:0]  cnt_rev;
    logic           brv_reg;
    logic           busy_reg;
    logic           start_err_reg;
    logic [LAT-1:0] rdy_pipe_reg;
    logic           ram_we_next;
    logic [AW-1:0]  ram_addr_next;

    // Bit-reversed view of the counter: bit gi takes counter bit AW-1-gi.
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt_reg[AW-1-gi];
        end
    endgenerate

    // Frame sequencer: load N samples, then drain N addresses; all steps gated by ED.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            brv_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (bus.ED) begin
            case (state_reg)
                IDLE: begin
                    if (bus.START) begin
                        // Sample 0 is written in this cycle, so LOAD resumes at address 1.
                        cnt_reg   <= AW'(1);
                        brv_reg   <= bus.BITREV;
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt_reg == LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + AW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_reg == LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + AW'(1);
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle error pulse for a START that arrives while a frame is in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_err_reg <= 1'b0;
        end else begin
            start_err_reg <= bus.ED && bus.START && (state_reg != IDLE);
        end
    end

    // Read-valid pipeline tracking the RAM read latency; shifts only on ED cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdy_pipe_reg <= '0;
        end else if (bus.ED) begin
            rdy_pipe_reg[0] <= (state_reg == DRAIN);
            for (int i = 1; i < LAT; i++) begin
                rdy_pipe_reg[i] <= rdy_pipe_reg[i-1];
            end
        end
    end

    // RAM write enable and address decode from the current state.
    always_comb begin
        ram_we_next   = 1'b0;
        ram_addr_next = '0;
        case (state_reg)
            IDLE:  ram_we_next = bus.START;
            LOAD: begin
                ram_we_next   = 1'b1;
                ram_addr_next = cnt_reg;
            end
            DRAIN: ram_addr_next = brv_reg ? cnt_rev : cnt_reg;
            default: begin
                ram_we_next   = 1'b0;
                ram_addr_next = '0;
            end
        endcase
    end

    assign bus.RAM_ED    = bus.ED;
    assign bus.RAM_WE    = ram_we_next;
    assign bus.RAM_ADDR  = ram_addr_next;
    // DO is frozen while ED is low, so RDY is qualified by ED to flag each word exactly once.
    assign bus.RDY       = rdy_pipe_reg[LAT-1] & bus.ED;
    assign bus.BUSY      = busy_reg;
    assign bus.START_ERR = start_err_reg;
endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Directed testbench for fft_reorder_ctrl with a behavioural 2-cycle,
// ED-gated single-port RAM on the controller's RAM outputs.
module tb_fft_reorder_ctrl;
    localparam int AW  = 6;
    localparam int LAT = 2;
    localparam int N   = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_reorder_ctrl_if #(.AW(AW)) bus ();

    fft_reorder_ctrl #(.AW(AW), .LAT(LAT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Frame buffer model: write on WE, read data appears LAT enabled cycles later.
    logic [7:0] di;
    logic [7:0] dout;
    logic [7:0] ram_s1;
    logic [7:0] mem [0:N-1];
    always @(posedge clk) begin
        if (bus.RAM_ED) begin
            if (bus.RAM_WE) mem[bus.RAM_ADDR] <= di;
            ram_s1 <= mem[bus.RAM_ADDR];
            dout   <= ram_s1;
        end
    end

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         cyc;
    int         first_rdy;
    int         last_rdy;
    int         rdy_off;
    logic [7:0] got_q [$];
    logic       rdy_log  [0:511];
    logic       busy_log [0:511];
    logic       se_log   [0:511];

    function automatic logic [5:0] brev(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.BITREV = 1'b0;
        bus.ED     = 1'b1;
        di         = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        cyc       = 0;
        first_rdy = -1;
        last_rdy  = -1;
        rdy_off   = 0;
        got_q.delete();
        for (int i = 0; i < 512; i++) begin
            rdy_log[i]  = 1'b0;
            busy_log[i] = 1'b0;
            se_log[i]   = 1'b0;
        end
    endtask

    // Drive one clock cycle, record the outputs, then advance to the next cycle.
    task automatic drive(input logic r, input logic st, input logic br, input logic ed, input logic [7:0] d);
        rst        = r;
        bus.START  = st;
        bus.BITREV = br;
        bus.ED     = ed;
        di         = d;
        #1;
        rdy_log[cyc]  = bus.RDY;
        busy_log[cyc] = bus.BUSY;
        se_log[cyc]   = bus.START_ERR;
        if (bus.RDY !== 1'b0) begin
            got_q.push_back(dout);
            if (first_rdy < 0) first_rdy = cyc;
            last_rdy = cyc;
            if (!ed) rdy_off++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compare 64 collected words starting at off with base + (bitrev(k) or k).
    task automatic chk_seq(input string tag, input int off, input int base, input logic rev);
        int         bad;
        logic [7:0] e;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            e = 8'(base + (rev ? int'(brev(6'(k))) : k));
            if (off + k >= got_q.size()) bad++;
            else if (got_q[off+k] !== e) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int k;

        // Reset values
        do_reset();
        #1;
        chk("rst_rdy",  bus.RDY, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_serr", bus.START_ERR, 0);
        chk("rst_we",   bus.RAM_WE, 0);
        chk("rst_addr", bus.RAM_ADDR, 0);
        chk("rst_ramed", bus.RAM_ED, 1);
        #1;
        cyc = 0;

        // 1: natural load, bit-reversed read
        for (int t = 0; t < 136; t++) drive(1'b0, t == 0, 1'b1, 1'b1, (t < N) ? 8'(t) : 8'd0);
        chk("br_first",  first_rdy, 66);
        chk("br_last",   last_rdy, 129);
        chk("br_count",  got_q.size(), 64);
        chk("br_w0", (got_q.size() > 4) ? got_q[0] : 8'hxx, 0);
        chk("br_w1", (got_q.size() > 4) ? got_q[1] : 8'hxx, 32);
        chk("br_w2", (got_q.size() > 4) ? got_q[2] : 8'hxx, 16);
        chk("br_w3", (got_q.size() > 4) ? got_q[3] : 8'hxx, 48);
        chk("br_w4", (got_q.size() > 4) ? got_q[4] : 8'hxx, 8);
        chk("br_w62", (got_q.size() == 64) ? got_q[62] : 8'hxx, 31);
        chk("br_w63", (got_q.size() == 64) ? got_q[63] : 8'hxx, 63);
        chk_seq("br_seq", 0, 0, 1'b1);
        chk("br_busy0",   busy_log[0], 0);
        chk("br_busy1",   busy_log[1], 1);
        chk("br_busy127", busy_log[127], 1);
        chk("br_busy128", busy_log[128], 0);

        // 2: natural read order
        do_reset();
        for (int t = 0; t < 136; t++) drive(1'b0, t == 0, 1'b0, 1'b1, (t < N) ? 8'(t) : 8'd0);
        chk("nat_first", first_rdy, 66);
        chk("nat_last",  last_rdy, 129);
        chk("nat_count", got_q.size(), 64);
        chk_seq("nat_seq", 0, 0, 1'b0);

        // 3: ED gaps during load and drain (2 cycles high, 3 low, repeating)
        do_reset();
        k = 0;
        for (int t = 0; t < 400; t++) begin
            drive(1'b0, t == 0, 1'b1, (t % 5) < 2, (k < N) ? 8'(k) : 8'd0);
            if ((t % 5) < 2) k++;
        end
        chk("ed_count",  got_q.size(), 64);
        chk("ed_rdyoff", rdy_off, 0);
        chk_seq("ed_seq", 0, 0, 1'b1);
        chk("ed_busy_end", busy_log[399], 0);

        // 4: back-to-back frames, second START at cycle 128
        do_reset();
        for (int t = 0; t < 266; t++) begin
            if (t < N)                      drive(1'b0, t == 0, 1'b1, 1'b1, 8'(t));
            else if (t >= 128 && t < 192)   drive(1'b0, t == 128, 1'b1, 1'b1, 8'(100 + t - 128));
            else                            drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        end
        chk("b2b_count",  got_q.size(), 128);
        chk("b2b_rdy129", rdy_log[129], 1);
        chk("b2b_rdy130", rdy_log[130], 0);
        chk("b2b_rdy193", rdy_log[193], 0);
        chk("b2b_rdy194", rdy_log[194], 1);
        chk("b2b_rdy257", rdy_log[257], 1);
        chk("b2b_rdy258", rdy_log[258], 0);
        chk("b2b_busy129", busy_log[129], 1);
        chk("b2b_serr129", se_log[129], 0);
        chk("b2b_w64", (got_q.size() > 66) ? got_q[64] : 8'hxx, 100);
        chk("b2b_w65", (got_q.size() > 66) ? got_q[65] : 8'hxx, 132);
        chk("b2b_w66", (got_q.size() > 66) ? got_q[66] : 8'hxx, 116);
        chk_seq("b2b_seq1", 0, 0, 1'b1);
        chk_seq("b2b_seq2", 64, 100, 1'b1);

        // 5: illegal START in LOAD and DRAIN, with BITREV=0 to show it is not latched
        do_reset();
        for (int t = 0; t < 136; t++)
            drive(1'b0, (t == 0) || (t == 10) || (t == 80), t == 0, 1'b1, (t < N) ? 8'(t) : 8'd0);
        chk("ill_serr1",  se_log[1], 0);
        chk("ill_serr10", se_log[10], 0);
        chk("ill_serr11", se_log[11], 1);
        chk("ill_serr12", se_log[12], 0);
        chk("ill_serr81", se_log[81], 1);
        chk("ill_serr82", se_log[82], 0);
        chk("ill_count",  got_q.size(), 64);
        chk("ill_first",  first_rdy, 66);
        chk_seq("ill_seq", 0, 0, 1'b1);
        chk("ill_busy128", busy_log[128], 0);

        // 6: reset mid-frame at cycle 70, restart at cycle 75
        do_reset();
        for (int t = 0; t < 216; t++) begin
            if (t < N)                    drive(1'b0, t == 0, 1'b1, 1'b1, 8'(t));
            else if (t == 70)             drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
            else if (t >= 75 && t < 139)  drive(1'b0, t == 75, 1'b1, 1'b1, 8'(50 + t - 75));
            else                          drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        end
        chk("mid_rdy70",   rdy_log[70], 1);
        chk("mid_rdy71",   rdy_log[71], 0);
        chk("mid_busy71",  busy_log[71], 0);
        chk("mid_busy76",  busy_log[76], 1);
        chk("mid_rdy140",  rdy_log[140], 0);
        chk("mid_rdy141",  rdy_log[141], 1);
        chk("mid_rdy204",  rdy_log[204], 1);
        chk("mid_rdy205",  rdy_log[205], 0);
        chk("mid_count",   got_q.size(), 69);
        chk_seq("mid_seq", 5, 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
